fnorm_seq: RTL and testbench

Sequential post-adder normalizer for single-precision floats. Sits directly downstream of the combinational float adder. It accepts the adder's raw result: sign, larger-operand exponent, and an un-normalized 25-bit magnitude including the carry bit. It normalizes the magnitude by shifting and adjusting the exponent, handles zero, overflow and underflow, and emits a packed IEEE-754 word over a valid/ready handshake.

---
 rtl/fp_pkg.sv | 17 +
 rtl/fnorm_seq_if.sv | 25 ++
 rtl/lzc24.sv | 16 +
 rtl/fnorm_seq.sv | 117 +++++++++++
 tb/tb_fnorm_seq.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared float-normalizer types and constants: FSM encoding, field widths, special words.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 25;
  localparam int WORD_W = 32;

  localparam logic [EXP_W-1:0]  EXP_MAX  = 8'hFF;
  localparam logic [WORD_W-1:0] POS_ZERO = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fnorm_seq_if.sv
// Handshake bundle between the float adder, the normalizer and its consumer.
interface fnorm_seq_if;
  import fp_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                in_sign;
  logic [EXP_W-1:0]    in_exp;
  logic [MANT_W-1:0]   in_mant;
  logic                out_valid;
  logic                out_ready;
  logic [WORD_W-1:0]   out;

  // master: adder side driving operands and consuming the result
  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out
  );

endinterface

// File: rtl/lzc24.sv
// Combinational leading-zero counter over 24 bits; count is 24 for an all-zero input.
// Latency: none (pure combinational). Backpressure: not applicable.
module lzc24 (
  input  logic [23:0] din,
  output logic [4:0]  cnt
);

  // ascending scan: the highest set bit is the last to write cnt
  always_comb begin
    cnt = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (din[i]) cnt = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fnorm_seq.sv
// Post-adder float normalizer: shifts a raw 25-bit sum into a packed IEEE-754 word (FNORM_LZC_EN: single-cycle shift).
// Latency: out_valid high n+2 edges after acceptance (n = left shifts); always 2 with FNORM_LZC_EN.
// Backpressure: one op in flight; in_ready only in IDLE; result held in DONE until out_ready.
module fnorm_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  fnorm_seq_if.slave  bus
);

  state_t              state_q, state_d;
  logic                sign_q, sign_d;
  logic [EXP_W:0]      exp_q, exp_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic [WORD_W-1:0]   out_q, out_d;

  logic [EXP_W:0]      exp_inc;
  logic [EXP_W:0]      exp_w;
  logic [MANT_W-1:0]   mant_w;

  // nine-bit exponent so the carry into 255 is seen before truncation
  assign exp_inc = exp_q + 9'd1;

`ifdef FNORM_LZC_EN
  logic [4:0]          lz;
  logic [EXP_W:0]      lz_ext;
  logic [EXP_W:0]      exp_m1;
  logic [EXP_W:0]      shamt;

  lzc24 u_lzc (
    .din (mant_q[23:0]),
    .cnt (lz)
  );

  assign lz_ext = {4'd0, lz};
  assign exp_m1 = exp_q - 9'd1;
  assign shamt  = (exp_q <= 9'd1) ? '0 : ((lz_ext < exp_m1) ? lz_ext : exp_m1);
  assign mant_w = mant_q << shamt;
  assign exp_w  = exp_q - shamt;
`else
  assign mant_w = mant_q;
  assign exp_w  = exp_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      out_q   <= POS_ZERO;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    out_d   = out_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sign_d  = bus.in_sign;
          exp_d   = {1'b0, bus.in_exp};
          mant_d  = bus.in_mant;
          state_d = ST_NORM;
        end
      end

      ST_NORM: begin
        state_d = ST_DONE;
        if (exp_q == {1'b0, EXP_MAX}) begin
          out_d = {sign_q, exp_q[EXP_W-1:0], mant_q[22:0]};
        end else if (mant_q == '0) begin
          out_d = POS_ZERO;
        end else if (mant_q[24]) begin
          if (exp_inc == {1'b0, EXP_MAX})
            out_d = {sign_q, EXP_MAX, 23'd0};
          else
            out_d = {sign_q, exp_inc[EXP_W-1:0], mant_q[23:1]};
        end else if (mant_w[23]) begin
          // a denormal sum that reached the hidden bit becomes the smallest normal
          out_d = {sign_q, (exp_w == 9'd0) ? 8'd1 : exp_w[EXP_W-1:0], mant_w[22:0]};
        end else if (exp_w <= 9'd1) begin
          out_d = {sign_q, 8'd0, mant_w[22:0]};
        end else begin
          mant_d  = mant_w << 1;
          exp_d   = exp_w - 9'd1;
          state_d = ST_NORM;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out       = out_q;

  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=> $stable(bus.out));

endmodule

// File: tb/tb_fnorm_seq.sv
// Randomized self-checking bench for fnorm_seq against a value-level normalization model.
module tb_fnorm_seq;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fnorm_seq_if bus ();

  fnorm_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%08h want=%08h", tag, got, want);
    end
  endtask

  // Normalize by value: place the leading one at bit 23 without dropping
  // below the minimum exponent; report how many left shifts that took.
  function automatic logic [31:0] ref_norm(input logic s, input logic [7:0] e,
                                           input logic [24:0] m, output int shifts);
    int mi, ei, p, sh;
    logic [7:0]  ef;
    logic [22:0] ff;
    shifts = 0;
    mi = int'(m);
    if (e == 8'hFF) return {s, e, m[22:0]};
    if (mi == 0) return 32'h0;
    if (mi >= (1 << 24)) begin
      ei = int'(e) + 1;
      if (ei >= 255) return {s, 8'hFF, 23'h0};
      ef = 8'(ei);
      ff = 23'((mi >> 1) & 32'h7FFFFF);
      return {s, ef, ff};
    end
    p = 0;
    for (int i = 0; i < 24; i++) if (((mi >> i) & 1) == 1) p = i;
    ei = (e == 8'd0) ? 1 : int'(e);
    sh = 23 - p;
    if (sh > ei - 1) sh = ei - 1;
    shifts = sh;
    mi = mi << sh;
    ff = 23'(mi & 32'h7FFFFF);
    ef = ((mi & 32'h800000) != 0) ? 8'(ei - sh) : 8'd0;
    return {s, ef, ff};
  endfunction

  // Latency counts edges from the accepting edge to the first edge with out_valid high.
  task automatic do_op(input logic s, input logic [7:0] e, input logic [24:0] m, input int hold);
    logic [31:0] want;
    int shifts, lat, want_lat;
    bit seen;
    want = ref_norm(s, e, m, shifts);
`ifdef FNORM_LZC_EN
    want_lat = 2;
`else
    want_lat = shifts + 2;
`endif
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'($urandom);
    bus.in_exp   = 8'($urandom);
    bus.in_mant  = 25'($urandom);
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    lat  = 1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!seen) begin
      check("timeout", 32'd0, 32'd1);
      return;
    end
    check("result", bus.out, want);
    check("latency", 32'(lat), 32'(want_lat));
    check("no_in_ready_in_done", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_out", bus.out, want);
      check("hold_valid", 32'(bus.out_valid & ~bus.in_ready), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("back_to_idle", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0]  d_exp [7];
    logic [24:0] d_mant[7];
    logic        d_sign[7];
    logic [24:0] m;
    logic [7:0]  e;
    int          vcount;

    total = 0;
    bad   = 0;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = 8'h0;
    bus.in_mant   = 25'h0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", bus.out, 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    d_sign = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    d_exp  = '{8'h7F, 8'h7F, 8'h7F, 8'h55, 8'hFE, 8'h03, 8'hFF};
    d_mant = '{25'h0800000, 25'h1000000, 25'h0000001, 25'h0000000,
               25'h1000000, 25'h0000100, 25'h1234567};
    for (int i = 0; i < 7; i++) do_op(d_sign[i], d_exp[i], d_mant[i], 0);

    // hold result under backpressure
    do_op(1'b1, 8'h10, 25'h0004000, 5);

    for (int i = 0; i < 200; i++) begin
      m = 25'($urandom) >> $urandom_range(0, 24);
      case ($urandom_range(0, 4))
        0:       e = 8'($urandom_range(0, 3));
        1:       e = 8'($urandom_range(252, 255));
        default: e = 8'($urandom);
      endcase
      do_op(1'($urandom), e, m, $urandom_range(0, 3));
    end

    // reset while normalizing: no result may surface afterwards
    bus.in_sign  = 1'b0;
    bus.in_exp   = 8'h7F;
    bus.in_mant  = 25'h0000001;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_norm_valid", 32'(bus.out_valid), 32'd0);
    check("rst_norm_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) vcount++;
    end
    check("no_stale_after_rst", 32'(vcount), 32'd0);
    bus.out_ready = 1'b0;

    // reset while a result is waiting
    bus.in_sign  = 1'b1;
    bus.in_exp   = 8'h40;
    bus.in_mant  = 25'h0800000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("done_before_rst", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_done_valid", 32'(bus.out_valid), 32'd0);
    check("rst_done_out", bus.out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(1'b0, 8'h7F, 25'h0800000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
